// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light phase scheduler.
// TL_ALLRED_EN inserts an all-red phase after each yellow.
package tl_pkg;

  typedef enum logic [2:0] {
    NSG, NSY, ARA, EWG, EWY, ARB, OFF, FLASH
  } phase_t;

  localparam int NS_R = 5;
  localparam int NS_Y = 4;
  localparam int NS_G = 3;
  localparam int EW_R = 2;
  localparam int EW_Y = 1;
  localparam int EW_G = 0;

  localparam logic [5:0] LED_NSG  = (6'b1 << NS_G) | (6'b1 << EW_R);
  localparam logic [5:0] LED_NSY  = (6'b1 << NS_Y) | (6'b1 << EW_R);
  localparam logic [5:0] LED_EWG  = (6'b1 << NS_R) | (6'b1 << EW_G);
  localparam logic [5:0] LED_EWY  = (6'b1 << NS_R) | (6'b1 << EW_Y);
  localparam logic [5:0] LED_AR   = (6'b1 << NS_R) | (6'b1 << EW_R);
  localparam logic [5:0] LED_DARK = 6'b0;

  localparam int Y_LEN_C = 3;
  localparam int AR_LEN  = 2;

  function automatic phase_t next_phase(input phase_t s);
    case (s)
`ifdef TL_ALLRED_EN
      NSG:     return NSY;
      NSY:     return ARA;
      ARA:     return EWG;
      EWG:     return EWY;
      EWY:     return ARB;
      default: return NSG;
`else
      NSG:     return NSY;
      NSY:     return EWG;
      EWG:     return EWY;
      default: return NSG;
`endif
    endcase
  endfunction

  function automatic logic [5:0] phase_led(input phase_t s);
    case (s)
      NSG:      return LED_NSG;
      NSY:      return LED_NSY;
      EWG:      return LED_EWG;
      EWY:      return LED_EWY;
      ARA, ARB: return LED_AR;
      default:  return LED_DARK;
    endcase
  endfunction

  function automatic logic [5:0] flash_led(input logic ph);
    logic [5:0] l;
    l = LED_DARK;
    l[NS_Y] = ph;
    l[EW_Y] = ph;
    return l;
  endfunction

endpackage

// File: rtl/tl_countdown.sv
// Loadable seconds down-counter; expire flags the tick that ends the phase.
module tl_countdown #(
  parameter int TW      = 5,
  parameter int RST_VAL = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          hold,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] rest,
  output logic          expire
);

  assign expire = tick && (rest == TW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rest <= TW'(RST_VAL);
    else if (load)
      rest <= load_val;
    else if (tick && !hold && rest != '0)
      rest <= rest - TW'(1);
  end

endmodule

// File: rtl/tl_phase_sched.sv
// Traffic-light phase sequencer: lamps, countdown, next-phase preview, online programming.
// TL_ALLRED_EN adds all-red phases ARA/ARB between yellow and the opposite green.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int G_DEF   = 20,
  parameter int E_DEF   = 15,
  parameter int Y_LEN   = Y_LEN_C,
  parameter int MIN_LEN = 4,
  parameter int TW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          off_r,
  input  logic          pause_r,
  input  logic          star_change,
  input  logic          online,
  input  logic          green_change,
  input  logic          red_change,
  input  logic [TW-1:0] set_time,
  output logic [5:0]    led_state,
  output logic [TW-1:0] rest_time,
  output logic [TW-1:0] next_time,
  output logic          cfg_ack
);

  phase_t        state, nxt;
  logic [TW-1:0] g_len, e_len, g_sh, e_sh;
  logic [TW-1:0] cnt_val, new_len, new_next;
  logic          green_q, red_q, flash_ph;
  logic          green_rise, red_rise, req_ok, dark, dark_req;
  logic          cnt_load, cnt_hold, expire;

  function automatic logic [TW-1:0] phase_len(input phase_t s, input logic [TW-1:0] g,
                                              input logic [TW-1:0] e);
    case (s)
      NSG:      return g;
      EWG:      return e;
      NSY, EWY: return TW'(Y_LEN);
      ARA, ARB: return TW'(AR_LEN);
      default:  return '0;
    endcase
  endfunction

  // Lengths for the phase being entered come from the shadows, which become live at this boundary.
  always_comb begin
    green_rise = green_change & ~green_q;
    red_rise   = red_change & ~red_q;
    req_ok     = online && (set_time >= TW'(MIN_LEN));
    dark_req   = off_r | star_change;
    dark       = (state == OFF) || (state == FLASH);
    nxt        = next_phase(state);
    new_len    = phase_len(nxt, g_sh, e_sh);
    new_next   = phase_len(next_phase(nxt), g_sh, e_sh);
    cnt_load   = 1'b0;
    cnt_hold   = pause_r;
    cnt_val    = new_len;
    if (dark_req) begin
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else if (dark) begin
      cnt_load = 1'b1;
      cnt_val  = g_len;
    end else if (!pause_r && expire) begin
      cnt_load = 1'b1;
    end
  end

  tl_countdown #(.TW(TW), .RST_VAL(G_DEF)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .hold     (cnt_hold),
    .load     (cnt_load),
    .load_val (cnt_val),
    .rest     (rest_time),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NSG;
      led_state <= LED_NSG;
      next_time <= TW'(Y_LEN);
      g_len     <= TW'(G_DEF);
      e_len     <= TW'(E_DEF);
      g_sh      <= TW'(G_DEF);
      e_sh      <= TW'(E_DEF);
      cfg_ack   <= 1'b0;
      flash_ph  <= 1'b0;
      green_q   <= 1'b0;
      red_q     <= 1'b0;
    end else begin
      green_q <= green_change;
      red_q   <= red_change;
      cfg_ack <= 1'b0;
      if (green_rise && req_ok) begin
        g_sh    <= set_time;
        cfg_ack <= 1'b1;
      end else if (red_rise && req_ok) begin
        e_sh    <= set_time;
        cfg_ack <= 1'b1;
      end

      if (off_r) begin
        state     <= OFF;
        led_state <= LED_DARK;
        next_time <= '0;
        flash_ph  <= 1'b0;
      end else if (star_change) begin
        state     <= FLASH;
        next_time <= '0;
        flash_ph  <= flash_ph ^ tick;
        led_state <= flash_led(flash_ph ^ tick);
      end else if (dark) begin
        state     <= NSG;
        led_state <= LED_NSG;
        next_time <= TW'(Y_LEN);
        flash_ph  <= 1'b0;
      end else if (!pause_r && expire) begin
        state     <= nxt;
        led_state <= phase_led(nxt);
        next_time <= new_next;
        g_len     <= g_sh;
        e_len     <= e_sh;
      end
    end
  end

endmodule

// File: tb/tb_tl_phase_sched.sv
// Bench for tl_phase_sched: directed steps plus random stimulus against a phase-table reference model.
module tb_tl_phase_sched;

  localparam int TW = 5;
  localparam int W  = 6 + 2 * TW + 1;
`ifdef TL_ALLRED_EN
  localparam int NPH      = 6;
  localparam int AR_T     = 4;
  localparam int NSY_NEXT = 2;
`else
  localparam int NPH      = 4;
  localparam int AR_T     = 0;
  localparam int NSY_NEXT = 15;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0, off_r = 1'b0, pause_r = 1'b0, star_change = 1'b0;
  logic          online = 1'b0, green_change = 1'b0, red_change = 1'b0;
  logic [TW-1:0] set_time = '0;
  logic [5:0]    led_state;
  logic [TW-1:0] rest_time, next_time;
  logic          cfg_ack;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  tl_phase_sched dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .off_r        (off_r),
    .pause_r      (pause_r),
    .star_change  (star_change),
    .online       (online),
    .green_change (green_change),
    .red_change   (red_change),
    .set_time     (set_time),
    .led_state    (led_state),
    .rest_time    (rest_time),
    .next_time    (next_time),
    .cfg_ack      (cfg_ack)
  );

  always #5 clk = ~clk;

  // Reference model: a table of phases (lamp pattern + length kind), walked by index.
  logic [5:0] pat [NPH];
  int         kind [NPH];   // 0 NS green, 1 EW green, 2 yellow, 3 all-red
  int         m_idx, m_rest, m_next, m_g, m_e, m_gsh, m_esh;
  logic [5:0] m_led;
  logic       m_ack, m_fl, m_dark, m_pg, m_pr;

  function automatic int plen(input int i);
    case (kind[i])
      0:       return m_g;
      1:       return m_e;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_idx = 0; m_rest = 20; m_next = 3; m_led = 6'b001_100;
    m_g = 20; m_e = 15; m_gsh = 20; m_esh = 15;
    m_ack = 1'b0; m_fl = 1'b0; m_dark = 1'b0; m_pg = 1'b0; m_pr = 1'b0;
  endtask

  task automatic model_eval();
    m_ack = 1'b0;
    if (online && set_time >= 4) begin
      if (green_change && !m_pg) begin
        m_gsh = set_time; m_ack = 1'b1;
      end else if (red_change && !m_pr) begin
        m_esh = set_time; m_ack = 1'b1;
      end
    end
    m_pg = green_change;
    m_pr = red_change;
    if (off_r) begin
      m_dark = 1'b1; m_fl = 1'b0; m_led = 6'b0; m_rest = 0; m_next = 0;
    end else if (star_change) begin
      m_dark = 1'b1;
      if (tick) m_fl = !m_fl;
      m_led = m_fl ? 6'b010_010 : 6'b000_000;
      m_rest = 0; m_next = 0;
    end else if (m_dark) begin
      m_dark = 1'b0; m_fl = 1'b0; m_idx = 0; m_led = pat[0]; m_rest = m_g; m_next = 3;
    end else if (!pause_r && tick) begin
      if (m_rest > 1) m_rest = m_rest - 1;
      else begin
        m_g = m_gsh; m_e = m_esh;
        m_idx = (m_idx + 1) % NPH;
        m_led = pat[m_idx];
        m_rest = plen(m_idx);
        m_next = plen((m_idx + 1) % NPH);
      end
    end
    exp_q.push_back({m_led, m_rest[TW-1:0], m_next[TW-1:0], m_ack});
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs now (just after a rising edge), check just after the next edge.
  task automatic step(input logic tk);
    logic [W-1:0] e;
    tick = tk;
    model_eval();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("led", 32'(led_state), 32'(e[W-1 -: 6]));
    chk("rest", 32'(rest_time), 32'(e[2*TW:TW+1]));
    chk("next", 32'(next_time), 32'(e[TW:1]));
    chk("ack", 32'(cfg_ack), 32'(e[0]));
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  task automatic pulse_green();
    green_change = 1'b1;
    step(1'b0);
    green_change = 1'b0;
  endtask

  initial begin
`ifdef TL_ALLRED_EN
    pat[0] = 6'b001_100; kind[0] = 0;
    pat[1] = 6'b010_100; kind[1] = 2;
    pat[2] = 6'b100_100; kind[2] = 3;
    pat[3] = 6'b100_001; kind[3] = 1;
    pat[4] = 6'b100_010; kind[4] = 2;
    pat[5] = 6'b100_100; kind[5] = 3;
`else
    pat[0] = 6'b001_100; kind[0] = 0;
    pat[1] = 6'b010_100; kind[1] = 2;
    pat[2] = 6'b100_001; kind[2] = 1;
    pat[3] = 6'b100_010; kind[3] = 2;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led_state), 32'b001_100);
    chk("rst_rest", 32'(rest_time), 20);
    chk("rst_next", 32'(next_time), 3);
    chk("rst_ack", 32'(cfg_ack), 0);
    rst = 1'b0;
    model_reset();

    // Full NS green then into yellow
    ticks(19);
    chk("nsg_last", 32'(rest_time), 1);
    chk("nsg_led", 32'(led_state), 32'b001_100);
    ticks(1);
    chk("nsy_led", 32'(led_state), 32'b010_100);
    chk("nsy_rest", 32'(rest_time), 3);
    chk("nsy_next", 32'(next_time), NSY_NEXT);
    ticks(21 + AR_T);
    chk("wrap_led", 32'(led_state), 32'b001_100);
    chk("wrap_rest", 32'(rest_time), 20);

    // Program NS green to 10 with 12 s left
    ticks(8);
    chk("pre_prog", 32'(rest_time), 12);
    online = 1'b1; set_time = 5'd10;
    pulse_green();
    chk("prog_ack", 32'(cfg_ack), 1);
    step(1'b0);
    chk("prog_ack_end", 32'(cfg_ack), 0);
    ticks(11);
    chk("not_retimed", 32'(rest_time), 1);
    ticks(1 + 21 + AR_T);
    chk("new_g_len", 32'(rest_time), 10);

    // Rejected requests
    set_time = 5'd2;
    pulse_green();
    chk("below_min", 32'(cfg_ack), 0);
    step(1'b0);
    online = 1'b0; set_time = 5'd12;
    pulse_green();
    chk("offline", 32'(cfg_ack), 0);
    step(1'b0);
    ticks(10 + 21 + AR_T);
    chk("g_unchanged", 32'(rest_time), 10);

    // Pause in EW green at 7
    ticks(10 + 3 + AR_T / 2);
    chk("ewg_led", 32'(led_state), 32'b100_001);
    ticks(8);
    chk("ewg_7", 32'(rest_time), 7);
    pause_r = 1'b1;
    ticks(5);
    chk("pause_rest", 32'(rest_time), 7);
    chk("pause_led", 32'(led_state), 32'b100_001);
    pause_r = 1'b0;
    ticks(1);
    chk("resume", 32'(rest_time), 6);

    // Flash, then off, then back to NS green
    star_change = 1'b1;
    step(1'b0);
    chk("flash_rest", 32'(rest_time), 0);
    chk("flash_led0", 32'(led_state), 0);
    step(1'b1);
    chk("flash_led1", 32'(led_state), 32'b010_010);
    step(1'b1);
    chk("flash_led2", 32'(led_state), 0);
    step(1'b1);
    off_r = 1'b1;
    step(1'b0);
    chk("off_led", 32'(led_state), 0);
    chk("off_next", 32'(next_time), 0);
    off_r = 1'b0; star_change = 1'b0;
    step(1'b0);
    chk("exit_led", 32'(led_state), 32'b001_100);
    chk("exit_rest", 32'(rest_time), 10);
    chk("exit_next", 32'(next_time), 3);

    // Simultaneous requests: green wins; then EW at exactly MIN_LEN
    online = 1'b1; set_time = 5'd9;
    green_change = 1'b1; red_change = 1'b1;
    step(1'b0);
    chk("both_ack", 32'(cfg_ack), 1);
    green_change = 1'b0; red_change = 1'b0;
    step(1'b0);
    chk("both_one_ack", 32'(cfg_ack), 0);
    ticks(10 + 3 + 15 + 3 + AR_T);
    chk("both_g9", 32'(rest_time), 9);
    set_time = 5'd4; red_change = 1'b1;
    step(1'b0);
    chk("min_ack", 32'(cfg_ack), 1);
    red_change = 1'b0;
    ticks(9 + 3 + AR_T / 2);
    chk("e_min", 32'(rest_time), 4);

    // Asynchronous reset mid-phase
    ticks(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_led", 32'(led_state), 32'b001_100);
    chk("arst_rest", 32'(rest_time), 20);
    chk("arst_next", 32'(next_time), 3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    ticks(20);
    chk("arst_nsy", 32'(rest_time), 3);
    chk("arst_e", 32'(next_time), NSY_NEXT);

    // Random traffic
    repeat (500) begin
      if ($urandom_range(0, 39) == 0) off_r = !off_r;
      if ($urandom_range(0, 29) == 0) star_change = !star_change;
      if ($urandom_range(0, 19) == 0) pause_r = !pause_r;
      if ($urandom_range(0, 9) == 0) online = !online;
      green_change = ($urandom_range(0, 7) == 0);
      red_change = ($urandom_range(0, 7) == 0);
      set_time = TW'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)));
    end
    off_r = 1'b0; star_change = 1'b0; pause_r = 1'b0;
    green_change = 1'b0; red_change = 1'b0;
    ticks(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
